fp_div_round_pack: RTL and testbench

//  Back end of the FP divide/sqrt datapath. Takes the raw quotient/root mantissa,
//  the pre-normalization biased exponent and special-case flags. Normalizes,

---
 rtl/fp_div_round_pack.sv | 155 +++++++++++++++
 tb/tb_fp_div_round_pack.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_div_round_pack
//  Description : FP divide/sqrt back end. Normalizes the raw quotient/root,
//                rounds to nearest-even, range-checks and packs an IEEE-754
//                word through a 2-stage valid/ready pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_div_round_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W+1:0]       in_e_pre,
    input  logic [MAN_W+2:0]       in_q,
    input  logic                   in_sticky,
    input  logic                   in_zero,
    input  logic                   in_inf,
    input  logic                   in_nan,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic                   out_inexact
);

    localparam logic signed [EXP_W+1:0] c_emax = (EXP_W+2)'((1 << EXP_W) - 1);

    // ---------------- handshake ----------------
    logic r_s1_v;
    logic r_s2_v;
    logic w_s1_en;
    logic w_s2_en;

    assign w_s2_en   = !r_s2_v || out_ready;
    assign w_s1_en   = !r_s1_v || w_s2_en;
    assign in_ready  = w_s1_en;
    assign out_valid = r_s2_v;

    // ---------------- stage 1: normalize + round ----------------
    logic             w_norm;
    logic [MAN_W-1:0] w_frac;
    logic             w_g;
    logic             w_r;
    logic             w_inc;
    logic [MAN_W:0]   w_sum;
    logic [EXP_W+1:0] w_e;
    logic             w_inexact;

    assign w_norm    = in_q[MAN_W+2];
    assign w_frac    = w_norm ? in_q[MAN_W+1:2] : in_q[MAN_W:1];
    assign w_g       = w_norm ? in_q[1] : in_q[0];
    assign w_r       = w_norm & in_q[0];
    assign w_inc     = w_g & (w_frac[0] | w_r | in_sticky);
    // A carry out can only come from an all-ones fraction, so the wrapped
    // fraction is already zero and represents the 2.0 -> 1.0 renormalization.
    assign w_sum     = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
    assign w_e       = in_e_pre - {{(EXP_W+1){1'b0}}, ~w_norm}
                                + {{(EXP_W+1){1'b0}}, w_sum[MAN_W]};
    assign w_inexact = w_g | w_r | in_sticky;

    logic             r_s1_sign;
    logic [EXP_W+1:0] r_s1_e;
    logic [MAN_W-1:0] r_s1_frac;
    logic             r_s1_inexact;
    logic             r_s1_zero;
    logic             r_s1_inf;
    logic             r_s1_nan;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_v       <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_e       <= '0;
            r_s1_frac    <= '0;
            r_s1_inexact <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_nan     <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_sign    <= in_sign;
                r_s1_e       <= w_e;
                r_s1_frac    <= w_sum[MAN_W-1:0];
                r_s1_inexact <= w_inexact;
                r_s1_zero    <= in_zero;
                r_s1_inf     <= in_inf;
                r_s1_nan     <= in_nan;
            end
        end
    end

    // ---------------- stage 2: range check + pack ----------------
    logic                 w_ovf_rng;
    logic                 w_unf_rng;
    logic [EXP_W+MAN_W:0] w_res;
    logic                 w_ovf;
    logic                 w_unf;
    logic                 w_inx;

    assign w_ovf_rng = $signed(r_s1_e) >= c_emax;
    assign w_unf_rng = r_s1_e[EXP_W+1] || (r_s1_e == '0);

    always_comb begin
        w_res = {r_s1_sign, r_s1_e[EXP_W-1:0], r_s1_frac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inx = r_s1_inexact;
        if (r_s1_nan) begin
            w_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_inx = 1'b0;
        end else if (r_s1_inf) begin
            w_res = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_inx = 1'b0;
        end else if (r_s1_zero) begin
            w_res = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
            w_inx = 1'b0;
        end else if (w_ovf_rng) begin
            w_res = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else if (w_unf_rng) begin
            // No subnormal support: anything below the normal range flushes.
            w_res = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
            w_unf = 1'b1;
            w_inx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_v      <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                out_result  <= w_res;
                out_ovf     <= w_ovf;
                out_unf     <= w_unf;
                out_inexact <= w_inx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_div_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_div_round_pack
//  Description : Self-checking bench for fp_div_round_pack: directed vector
//                table, handshake corner sequences and random beats against
//                an arithmetic rounding model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_round_pack;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_e_pre;
    logic [25:0] in_q;
    logic        in_sticky;
    logic        in_zero;
    logic        in_inf;
    logic        in_nan;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    fp_div_round_pack #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_e_pre(in_e_pre), .in_q(in_q),
        .in_sticky(in_sticky), .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [9:0]  e_pre;
        logic [25:0] q;
        logic        s, z, inf, nan;
        logic [31:0] res;
        logic        ovf, unf, inx;
    } beat_t;

    int          nvec  = 0;
    int          nfail = 0;
    logic [34:0] exp_q[$];
    logic [34:0] cur_exp;
    bit          rand_rdy = 0;
    beat_t       tbl[14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Rounding worked out on integers: keep the top 24 significant bits,
    // compare the discarded part against one half, ties go to even.
    function automatic logic [34:0] model(input beat_t b);
        int     e, sh;
        longint keep, rem, half, m;
        bit     up, inx;
        if (b.nan) return {32'h7FC00000, 3'b000};
        if (b.inf) return {b.sign, 8'hFF, 23'd0, 3'b000};
        if (b.z)   return {b.sign, 31'd0, 3'b000};
        sh   = b.q[25] ? 2 : 1;
        e    = int'($signed(b.e_pre)) - (2 - sh);
        keep = longint'(b.q) >> sh;
        rem  = longint'(b.q) % (longint'(1) << sh);
        half = longint'(1) << (sh - 1);
        up   = (rem > half) || (rem == half && (b.s || (keep % 2) == 1));
        inx  = (rem != 0) || b.s;
        m    = keep + longint'(up);
        if (m == (longint'(1) << 24)) begin
            m = m / 2;
            e++;
        end
        if (e >= 255) return {b.sign, 8'hFF, 23'd0, 3'b101};
        if (e <= 0)   return {b.sign, 31'd0, 3'b011};
        return {b.sign, 8'(e), 23'(m), 2'b00, inx};
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    e;
        int    edges[8] = '{-1, 0, 1, 2, 253, 254, 255, 256};
        logic [34:0] m;
        b.sign = 1'($urandom);
        if ($urandom_range(0, 1) == 1) b.q = {1'b1, 25'($urandom)};
        else                           b.q = {2'b01, 24'($urandom)};
        if ($urandom_range(0, 7) == 0) b.q[22:0] = '1;
        if ($urandom_range(0, 3) == 0) e = edges[$urandom_range(0, 7)];
        else                           e = int'($urandom_range(0, 300)) - 20;
        b.e_pre = 10'(e);
        b.s   = 1'($urandom);
        b.z   = ($urandom_range(0, 19) == 0);
        b.inf = ($urandom_range(0, 19) == 0);
        b.nan = ($urandom_range(0, 19) == 0);
        m = model(b);
        {b.res, b.ovf, b.unf, b.inx} = m;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_sign   = b.sign;
        in_e_pre  = b.e_pre;
        in_q      = b.q;
        in_sticky = b.s;
        in_zero   = b.z;
        in_inf    = b.inf;
        in_nan    = b.nan;
        cur_exp   = {b.res, b.ovf, b.unf, b.inx};
        in_valid  = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input beat_t b);
        int n = 0;
        bit acc;
        drive(b);
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on output transfer, push on input transfer.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 64'd1, 64'd0);
                end else begin
                    check("result", 64'({out_result, out_ovf, out_unf, out_inexact}),
                          64'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        sign e_pre    q             s  z  inf nan res           ovf unf inx
        tbl[0]  = '{0, 10'd128, 26'h3000000, 0, 0, 0, 0, 32'h40400000, 0, 0, 0};
        tbl[1]  = '{0, 10'd127, 26'h1555555, 1, 0, 0, 0, 32'h3F2AAAAB, 0, 0, 1};
        tbl[2]  = '{0, 10'd127, 26'h3FFFFFF, 0, 0, 0, 0, 32'h40000000, 0, 0, 1};
        tbl[3]  = '{0, 10'd255, 26'h2000000, 0, 0, 0, 0, 32'h7F800000, 1, 0, 1};
        tbl[4]  = '{1, 10'd1,   26'h1800000, 0, 0, 0, 0, 32'h80000000, 0, 1, 1};
        tbl[5]  = '{1, 10'd300, 26'h1234567, 1, 0, 1, 1, 32'h7FC00000, 0, 0, 0};
        tbl[6]  = '{1, 10'd127, 26'h3FFFFFF, 1, 1, 0, 0, 32'h80000000, 0, 0, 0};
        tbl[7]  = '{0, 10'd254, 26'h3FFFFFF, 0, 0, 0, 0, 32'h7F800000, 1, 0, 1};
        tbl[8]  = '{0, 10'd2,   26'h1800000, 0, 0, 0, 0, 32'h00C00000, 0, 0, 0};
        tbl[9]  = '{1, 10'd5,   26'h2ABCDEF, 1, 0, 1, 0, 32'hFF800000, 0, 0, 0};
        tbl[10] = '{0, 10'h3FB, 26'h2000000, 0, 0, 0, 0, 32'h00000000, 0, 1, 1};
        tbl[11] = '{0, 10'd127, 26'h2000002, 0, 0, 0, 0, 32'h3F800000, 0, 0, 1};
        tbl[12] = '{0, 10'd127, 26'h2000006, 0, 0, 0, 0, 32'h3F800002, 0, 0, 1};
        tbl[13] = '{0, 10'd254, 26'h2000000, 0, 0, 0, 0, 32'h7F000000, 0, 0, 0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_e_pre  = '0;
        in_q      = '0;
        in_sticky = 1'b0;
        in_zero   = 1'b0;
        in_inf    = 1'b0;
        in_nan    = 1'b0;
        out_ready = 1'b1;
        cur_exp   = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("reset_outputs", 64'({out_valid, out_result, out_ovf, out_unf, out_inexact}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: beat accepted at edge E0 is visible after E1.
        send(tbl[0]);
        @(negedge clk);
        check("latency_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_s2", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 14; i++) send(tbl[i]);
        drain();

        rand_rdy = 1;
        for (int i = 0; i < 400; i++) send(rand_beat());
        drain();
        rand_rdy  = 0;
        out_ready = 1'b0;

        // Backpressure: two beats fill the pipe, the third stalls.
        send(tbl[0]);
        send(tbl[1]);
        drive(tbl[2]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_hold", 64'({out_valid, out_result, out_ovf, out_unf, out_inexact}),
                  64'({1'b1, tbl[0].res, tbl[0].ovf, tbl[0].unf, tbl[0].inx}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        begin
            int n = 0;
            bit acc;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!acc && n < 50);
            if (!acc) check("stall_release_timeout", 64'(acc), 64'd1);
            in_valid = 1'b0;
        end
        drain();

        // Asynchronous reset while beats are in flight.
        send(tbl[3]);
        send(tbl[4]);
        check("midstream_busy", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midstream_reset", 64'({out_valid, out_result, out_ovf, out_unf, out_inexact}), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        send(tbl[1]);
        drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
